// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with optional even parity
`timescale 1ns/1ps

module piso_tx #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b0,
    parameter bit PARITY    = 1'b0
) (
    input  logic         clk,
    input  logic         clear,
    input  logic [N-1:0] d,
    input  logic         load,
    input  logic         en,
    output logic         sout,
    output logic         sout_valid,
    output logic         busy,
    output logic         done
);

    localparam int F  = N + (PARITY ? 1 : 0);
    localparam int CW = $clog2(F + 1);
    localparam logic [CW-1:0] F_CNT = CW'(F);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state, state_nx;
    logic [F-1:0]  shreg, shreg_nx, frame;
    logic [CW-1:0] cnt, cnt_nx;
    logic          sout_nx, valid_nx, busy_nx, done_nx;

    // Frame laid out in transmit order: bit 0 goes first, parity (if any) last.
    always_comb begin
        frame = '0;
        for (int i = 0; i < N; i++) begin
            frame[i] = MSB_FIRST ? d[N-1-i] : d[i];
        end
        if (PARITY) begin
            frame[F-1] = ^d;
        end
    end

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        sout_nx  = sout;
        valid_nx = sout_valid;
        busy_nx  = busy;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    sout_nx  = frame[0];
                    shreg_nx = {1'b0, frame[F-1:1]};
                    valid_nx = 1'b1;
                    busy_nx  = 1'b1;
                    cnt_nx   = CW'(1);
                    state_nx = SHIFT;
                end else begin
                    sout_nx  = 1'b0;
                    valid_nx = 1'b0;
                    busy_nx  = 1'b0;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (cnt == F_CNT) begin
                        sout_nx  = 1'b0;
                        valid_nx = 1'b0;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        shreg_nx = '0;
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        sout_nx  = shreg[0];
                        shreg_nx = {1'b0, shreg[F-1:1]};
                        cnt_nx   = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            cnt        <= cnt_nx;
            sout       <= sout_nx;
            sout_valid <= valid_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

endmodule
